seg_scan: RTL and testbench



---
 rtl/seg_scan.sv | 92 +++++++++
 tb/tb_seg_scan.sv | 121 ++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed common-anode 7-segment driver with per-frame shadow capture
// and ghost blanking; define SEG_LZB_EN for leading-zero blanking.
module seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GHOST    = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   dig_bus,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick
);
    localparam int DW = 20;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DW-1:0]         r_div;
    logic [SW-1:0]         r_slot;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg;
    logic [DIGITS-1:0]     w_sup;
    logic                  w_start;
    logic                  w_blank;
    logic                  w_div_wrap;

    assign w_div_wrap = (r_div == DW'(SCAN_DIV - 1));
    assign w_start    = (r_div == '0) && (r_slot == '0);
    assign w_digit    = 4'(r_shadow >> {r_slot, 2'b00});

`ifdef SEG_LZB_EN
    // A digit is suppressed while it and every more significant digit are zero.
    always_comb begin
        logic w_zero;
        w_zero = 1'b1;
        w_sup  = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero   = w_zero && (r_shadow[4*k +: 4] == 4'h0);
            w_sup[k] = w_zero;
        end
    end
`else
    assign w_sup = '0;
`endif

    assign w_blank = (r_div < DW'(GHOST)) || w_sup[r_slot];

    always_comb begin
        w_seg = 7'h7F;
        case (w_digit)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    // Capture happens at div==0, inside the blank window, so a new shadow is never half-shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= '0;
            r_slot     <= '0;
            r_shadow   <= '0;
            an_n       <= '1;
            seg_n      <= 7'h7F;
            frame_tick <= 1'b0;
        end else begin
            r_div      <= w_div_wrap ? '0 : r_div + 1'b1;
            if (w_div_wrap)
                r_slot <= (r_slot == SW'(DIGITS - 1)) ? '0 : r_slot + 1'b1;
            if (w_start)
                r_shadow <= dig_bus;
            frame_tick <= w_start;
            an_n       <= w_blank ? '1 : ~(DIGITS'(1) << r_slot);
            seg_n      <= w_blank ? 7'h7F : w_seg;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan with DIGITS=4, SCAN_DIV=8, GHOST=2;
// expectations follow SEG_LZB_EN the same way the design build does.
module tb_seg_scan;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GHOST    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dig_bus = 16'h1234;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GHOST(GHOST)) dut (
        .clk(clk), .reset(reset), .dig_bus(dig_bus),
        .seg_n(seg_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int last_tick = -1;
    int m_div = 0;
    int m_slot = 0;
    logic [15:0] m_shadow = '0;
    logic [11:0] q[$];
    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs for the coming edge are pushed before the edge, popped after it.
    task automatic cyc();
        logic [11:0] exp;
        logic        ft;
        logic        blank;
        logic [3:0]  an;
        logic [6:0]  seg;
        int          top;
        if (reset) begin
            exp = {1'b0, 4'hF, 7'h7F};
            m_div = 0;
            m_slot = 0;
            m_shadow = '0;
            last_tick = -1;
        end else begin
            ft = (m_div == 0 && m_slot == 0);
            top = 0;
            for (int k = 0; k < DIGITS; k++)
                if (m_shadow[4*k +: 4] != 4'h0) top = k;
            blank = (m_div < GHOST);
`ifdef SEG_LZB_EN
            if (m_slot > top) blank = 1'b1;
`endif
            an  = blank ? 4'hF : ~(4'b0001 << m_slot);
            seg = blank ? 7'h7F : dec[m_shadow[4*m_slot +: 4]];
            exp = {ft, an, seg};
            if (ft) m_shadow = dig_bus;
            if (m_div == SCAN_DIV - 1) begin
                m_div = 0;
                m_slot = (m_slot + 1) % DIGITS;
            end else begin
                m_div++;
            end
        end
        q.push_back(exp);
        @(posedge clk);
        #1;
        cycle++;
        chk($sformatf("out@%0d", cycle), {frame_tick, an_n, seg_n}, q.pop_front());
        if (frame_tick) begin
            if (last_tick >= 0)
                chk("tick_period", 12'(cycle - last_tick), 12'(DIGITS * SCAN_DIV));
            last_tick = cycle;
        end
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_an", {8'h0, an_n}, 12'h00F);
        chk("rst_seg", {5'h0, seg_n}, 12'h07F);
        chk("rst_tick", {11'h0, frame_tick}, 12'h000);
        reset = 1'b0;
        cyc();
        chk("first_tick", {11'h0, frame_tick}, 12'h001);
        cyc();
        chk("ghost_an", {8'h0, an_n}, 12'h00F);
        cyc();
        chk("d0_an", {8'h0, an_n}, 12'h00E);
        chk("d0_seg", {5'h0, seg_n}, 12'h019);
        repeat (40) cyc();
        for (int i = 0; i < 64 && !(m_slot == 2 && m_div == 3); i++) cyc();
        dig_bus = 16'h5678;
        repeat (70) cyc();
        dig_bus = 16'h0090;
        repeat (70) cyc();
        dig_bus = 16'h0000;
        repeat (70) cyc();
        dig_bus = 16'h1234;
        repeat (40) cyc();
        for (int i = 0; i < 64 && !(m_slot == 2 && m_div == 5); i++) cyc();
        reset = 1'b1;
        cyc();
        chk("pulse_rst", {frame_tick, an_n, seg_n}, {1'b0, 4'hF, 7'h7F});
        reset = 1'b0;
        cyc();
        chk("pulse_tick", {11'h0, frame_tick}, 12'h001);
        repeat (40) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
